// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the RISC-V fetch datapath: the canonical NOP
//   encoding, the sequential PC step and the fetch FSM state encoding.
//   A small helper forces an address onto a word boundary.
//   Optional build macro used by the fetch stage: FETCH_MISALIGN_TRAP_EN.
// ---------------------------------------------------------------------------
package riscv_pkg;

   // addi x0, x0, 0 -- the canonical RISC-V NOP, used as the bubble word
   localparam logic [31:0] NOP     = 32'h0000_0013;

   // Distance between consecutive instruction words in bytes
   localparam logic [31:0] PC_STEP = 32'd4;

   // Fetch FSM: BOOT after reset, RUN while fetching, DRAIN once the PC
   // has walked past the end of instruction memory
   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   // Clears the two byte-offset bits so the address lands on a word
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage_if
//   Bundles the fetch stage's control, memory and IF/ID signals.
//   master : hazard unit / instruction memory / decode side
//            drives Stall, Flush, BranchTarget, Instruction
//            observes ReadAddress, IfIdPc, IfIdInstr, IfIdValid, FetchDone
//   slave  : the fetch stage itself (directions reversed)
//   MisalignFault exists only when FETCH_MISALIGN_TRAP_EN is defined.
// ---------------------------------------------------------------------------
interface instruction_fetch_stage_if;

   logic        Stall;
   logic        Flush;
   logic [31:0] BranchTarget;
   logic [31:0] Instruction;
   logic [31:0] ReadAddress;
   logic [31:0] IfIdPc;
   logic [31:0] IfIdInstr;
   logic        IfIdValid;
   logic        FetchDone;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        MisalignFault;
`endif

`ifdef FETCH_MISALIGN_TRAP_EN
   modport master (
      output Stall, Flush, BranchTarget, Instruction,
      input  ReadAddress, IfIdPc, IfIdInstr, IfIdValid, FetchDone, MisalignFault
   );

   modport slave (
      input  Stall, Flush, BranchTarget, Instruction,
      output ReadAddress, IfIdPc, IfIdInstr, IfIdValid, FetchDone, MisalignFault
   );
`else
   modport master (
      output Stall, Flush, BranchTarget, Instruction,
      input  ReadAddress, IfIdPc, IfIdInstr, IfIdValid, FetchDone
   );

   modport slave (
      input  Stall, Flush, BranchTarget, Instruction,
      output ReadAddress, IfIdPc, IfIdInstr, IfIdValid, FetchDone
   );
`endif

endinterface

// File: rtl/instruction_fetch_stage_program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
//   Program-counter register with load / increment / hold.
//   Ports:
//     Clock       in   rising-edge clock
//     ResetN      in   asynchronous active-low reset, PC <= RESET_PC
//     load        in   take load_value (has priority over increment)
//     increment   in   advance by PC_STEP (wraps modulo 2^32)
//     load_value  in   32-bit redirect address
//     pc          out  current program counter
// ---------------------------------------------------------------------------
module program_counter
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clock,
   input  logic        ResetN,
   input  logic        load,
   input  logic        increment,
   input  logic [31:0] load_value,
   output logic [31:0] pc
);

   // A redirect beats sequential advance; with neither request the PC holds
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= load_value;
      end else if (increment) begin
         pc <= pc + PC_STEP;
      end
   end

endmodule

// File: rtl/instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage
//   PC plus IF/ID pipeline register for the RISC-V datapath. ReadAddress is
//   the PC; the combinational instruction memory answers with Instruction in
//   the same cycle and the pair {PC, Instruction} is captured into IF/ID.
//   Handles stall, branch/jump redirect with squash, and end-of-program drain.
//   Parameters:
//     RESET_PC   PC loaded on reset
//     MEM_WORDS  instruction memory depth in words (fetch limit MEM_WORDS*4)
//   Ports:
//     Clock      in   rising-edge clock
//     ResetN     in   asynchronous active-low reset
//     fetch      slave modport of instruction_fetch_stage_if
//   Build macro FETCH_MISALIGN_TRAP_EN: a redirect to a non-word-aligned
//   target raises a sticky MisalignFault and drains instead of loading.
//   Without it the two low target bits are simply cleared.
// ---------------------------------------------------------------------------
module instruction_fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_WORDS = 32
) (
   input  logic                      Clock,
   input  logic                      ResetN,
   instruction_fetch_stage_if.slave  fetch
);

   localparam logic [31:0] FETCH_LIMIT = 32'(MEM_WORDS * 4);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  pc_plus;
   logic [31:0]  target;
   logic         misaligned;
   logic         target_in_range;
   logic         pc_load;
   logic         pc_inc;
   logic [31:0]  ifid_pc;
   logic [31:0]  ifid_instr;
   logic         ifid_valid;
   logic         fetch_done;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic         misalign_fault;
`endif

   // With the trap enabled an unaligned target is rejected, so it is passed
   // through untouched; otherwise it is quietly snapped to a word boundary.
`ifdef FETCH_MISALIGN_TRAP_EN
   assign target     = fetch.BranchTarget;
   assign misaligned = (fetch.BranchTarget[1:0] != 2'b00);
`else
   assign target     = align_word(fetch.BranchTarget);
   assign misaligned = 1'b0;
`endif

   assign target_in_range = (target < FETCH_LIMIT);
   assign pc_plus         = pc + PC_STEP;

   // PC control. In RUN any accepted redirect loads the PC, even one that
   // lands past memory (that one also sends us to DRAIN). In DRAIN only an
   // in-range redirect restarts fetch; the PC otherwise stays parked.
   always_comb begin
      pc_load = 1'b0;
      pc_inc  = 1'b0;
      unique case (state)
         RUN: begin
            if (fetch.Flush) begin
               pc_load = !misaligned;
            end else if (!fetch.Stall) begin
               pc_inc = 1'b1;
            end
         end
         DRAIN: begin
            if (fetch.Flush && !misaligned && target_in_range) begin
               pc_load = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   program_counter #(
      .RESET_PC (RESET_PC)
   ) u_program_counter (
      .Clock      (Clock),
      .ResetN     (ResetN),
      .load       (pc_load),
      .increment  (pc_inc),
      .load_value (target),
      .pc         (pc)
   );

   // Fetch FSM together with the IF/ID register. Flush outranks Stall in
   // every state except BOOT, where both are ignored. A squash writes a
   // bubble (PC 0, NOP, not valid) so decode sees the same thing it sees
   // straight out of reset. FetchDone is registered alongside the state so
   // it is high exactly while we sit in DRAIN.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state          <= BOOT;
         ifid_pc        <= '0;
         ifid_instr     <= NOP;
         ifid_valid     <= 1'b0;
         fetch_done     <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_fault <= 1'b0;
`endif
      end else begin
         unique case (state)
            BOOT: begin
               state <= RUN;
            end

            RUN: begin
               if (fetch.Flush) begin
                  ifid_pc    <= '0;
                  ifid_instr <= NOP;
                  ifid_valid <= 1'b0;
                  if (misaligned) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                     misalign_fault <= 1'b1;
`endif
                     state      <= DRAIN;
                     fetch_done <= 1'b1;
                  end else if (!target_in_range) begin
                     state      <= DRAIN;
                     fetch_done <= 1'b1;
                  end
               end else if (!fetch.Stall) begin
                  ifid_pc    <= pc;
                  ifid_instr <= fetch.Instruction;
                  ifid_valid <= 1'b1;
                  if (pc_plus >= FETCH_LIMIT) begin
                     state      <= DRAIN;
                     fetch_done <= 1'b1;
                  end
               end
            end

            DRAIN: begin
               if (fetch.Flush) begin
                  ifid_pc    <= '0;
                  ifid_instr <= NOP;
                  ifid_valid <= 1'b0;
                  if (misaligned) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                     misalign_fault <= 1'b1;
`endif
                  end else if (target_in_range) begin
                     state      <= RUN;
                     fetch_done <= 1'b0;
                  end
               end else if (!fetch.Stall) begin
                  ifid_pc    <= '0;
                  ifid_instr <= NOP;
                  ifid_valid <= 1'b0;
               end
            end

            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

   assign fetch.ReadAddress   = pc;
   assign fetch.IfIdPc        = ifid_pc;
   assign fetch.IfIdInstr     = ifid_instr;
   assign fetch.IfIdValid     = ifid_valid;
   assign fetch.FetchDone     = fetch_done;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign fetch.MisalignFault = misalign_fault;
`endif

endmodule
